mem_io_ctrl: RTL

Memory/I-O access sequencer directly downstream of the SLC-3 datapath. It consumes MAR, MDR and the control FSM's memory request, and runs a multi-cycle, ack-handshaked SRAM read or write. Read data is returned on MDR_In, which the datapath loads into MDR when MIO_EN is set. Address IO_ADDR is decoded as memory-mapped I/O: reads return the synchronized switches, writes load the hex display register.

---
 rtl/slc3_mem_pkg.sv | 14 +
 rtl/mem_io_ctrl_sync2.sv | 26 ++
 rtl/mem_io_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O access sequencer.
package slc3_mem_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] IO_ADDR_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mem_io_ctrl.sv
// Multi-cycle ack-handshaked SRAM read/write sequencer with memory-mapped
// switch input and hex display register at IO_ADDR.
module mem_io_ctrl
    import slc3_mem_pkg::*;
#(
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [9:0]  SW,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_WData,
    output logic        Mem_WE,
    output logic        Mem_Req,
    input  logic [15:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic [15:0] MDR_In,
    output logic [15:0] HEX_Out,
    output logic        Done,
    output logic        Busy,
    output logic        Err
);

    localparam int unsigned SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETUP_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    mem_state_t r_state;
    mem_state_t w_next;

    logic [15:0]     r_mem_addr;
    logic [15:0]     r_mem_wdata;
    logic            r_mem_we;
    logic [15:0]     r_mdr_in;
    logic [15:0]     r_hex;
    logic            r_err;
    logic [SC_W-1:0] r_setup_cnt;
    logic [TO_W-1:0] r_to_cnt;

    logic [9:0] w_sw_sync;
    logic       w_is_io;
    logic       w_to_last;

    sync2 #(.WIDTH(10)) u_sw_sync (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_d     (SW),
        .o_q     (w_sw_sync)
    );

    assign w_is_io   = (MAR == IO_ADDR);
    assign w_to_last = (r_to_cnt == TO_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (Req) w_next = w_is_io ? DONE : SETUP;
            SETUP:    if (r_setup_cnt == '0) w_next = WAIT_ACK;
            WAIT_ACK: if (Mem_Ack || w_to_last) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // SRAM-facing registers load only for non-I/O accesses so IO_ADDR never
    // appears on Mem_Addr.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mdr_in    <= '0;
            r_hex       <= '0;
            r_err       <= 1'b0;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_err <= 1'b0;
                        if (w_is_io) begin
                            if (WE) r_hex    <= MDR;
                            else    r_mdr_in <= {6'b0, w_sw_sync};
                        end else begin
                            r_mem_addr  <= MAR;
                            r_mem_wdata <= MDR;
                            r_mem_we    <= WE;
                            r_setup_cnt <= SC_LOAD;
                        end
                    end
                end
                SETUP: begin
                    if (r_setup_cnt == '0) r_to_cnt    <= '0;
                    else                   r_setup_cnt <= r_setup_cnt - 1'b1;
                end
                WAIT_ACK: begin
                    // Ack takes priority over a coincident timeout.
                    if (Mem_Ack) begin
                        if (!r_mem_we) r_mdr_in <= Mem_RData;
                    end else if (w_to_last) begin
                        r_err <= 1'b1;
                        if (!r_mem_we) r_mdr_in <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mem_Addr  = r_mem_addr;
    assign Mem_WData = r_mem_wdata;
    assign Mem_WE    = r_mem_we;
    assign Mem_Req   = (r_state == WAIT_ACK);
    assign MDR_In    = r_mdr_in;
    assign HEX_Out   = r_hex;
    assign Done      = (r_state == DONE);
    assign Busy      = (r_state != IDLE);
    assign Err       = r_err;

endmodule
